// File: rtl/adc_avg_pkg.sv
// Shared widths and the FIFO entry payload for the ADC channel averager.
package adc_avg_pkg;

    localparam int unsigned ADC_DATA_W = 12;
    localparam int unsigned ADC_CH_W   = 5;

    typedef struct packed {
        logic [ADC_CH_W-1:0]   channel;
        logic [ADC_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/adc_channel_averager_if.sv
// Sample input stream, clear control and averaged-result output stream.
interface adc_channel_averager_if;
    import adc_avg_pkg::*;

    logic                  response_valid;
    logic [ADC_CH_W-1:0]   response_channel;
    logic [ADC_DATA_W-1:0] response_data;
    logic                  response_startofpacket;
    logic                  response_endofpacket;
    logic                  avg_clear;
    logic                  avg_valid;
    logic                  avg_ready;
    logic [ADC_CH_W-1:0]   avg_channel;
    logic [ADC_DATA_W-1:0] avg_data;
    logic                  overflow_sticky;

    modport master (
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket,
        output avg_clear, avg_ready,
        input  avg_valid, avg_channel, avg_data, overflow_sticky
    );

    modport slave (
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket,
        input  avg_clear, avg_ready,
        output avg_valid, avg_channel, avg_data, overflow_sticky
    );

endinterface

// File: rtl/adc_avg_fifo.sv
// First-word-fall-through result FIFO; full/empty derive from an occupancy count.
module adc_avg_fifo
    import adc_avg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        push_i,
    input  fifo_entry_t din_i,
    input  logic        pop_i,
    output fifo_entry_t dout_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t      mem_q [DEPTH];
    fifo_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_c  = pop_i && !empty_o;
        do_push_c = push_i && (!full_o || do_pop_c);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = din_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel block averager: sums 2^LOG2_AVG samples per channel and queues the
// rounded mean into a small result FIFO.
module adc_channel_averager
    import adc_avg_pkg::*;
#(
    parameter int unsigned LOG2_AVG   = 4,
    parameter int unsigned NUM_CH     = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clock_clk,
    input  logic                   reset_sink_reset_n,
    adc_channel_averager_if.slave  bus
);

    localparam int unsigned ACC_W = ADC_DATA_W + LOG2_AVG;
    localparam int unsigned RND_W = ACC_W + 1;
    localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int unsigned LAST  = (1 << LOG2_AVG) - 1;
    localparam int unsigned RND   = (LOG2_AVG > 0) ? (1 << (LOG2_AVG - 1)) : 0;

    logic             rst_meta_q;
    logic             rst_n;
    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic             sticky_q, sticky_d;

    logic [ADC_CH_W-1:0]   sel_c;
    logic                  ch_ok_c;
    logic                  last_c;
    logic [ACC_W-1:0]      sum_c;
    logic [RND_W-1:0]      rnd_c;
    logic [ADC_DATA_W-1:0] avg_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  drop_c;
    logic                  fifo_empty_c;
    logic                  fifo_full_c;
    fifo_entry_t           push_entry_c;
    fifo_entry_t           head_c;
    logic                  unused_c;

    // Asynchronous assert, two-flop synchronised release.
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n      <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n      <= rst_meta_q;
        end
    end

    assign unused_c = ^{bus.response_startofpacket, bus.response_endofpacket};

    assign sel_c   = bus.response_channel;
    assign ch_ok_c = bus.response_valid && !bus.avg_clear && (32'(sel_c) < NUM_CH);
    assign last_c  = (cnt_q[sel_c] == CNT_W'(LAST));
    assign sum_c   = acc_q[sel_c] + ACC_W'(bus.response_data);
    // Mean of 12-bit samples with half-LSB rounding cannot exceed 4095.
    assign rnd_c   = RND_W'(sum_c) + RND_W'(RND);
    assign avg_c   = ADC_DATA_W'(rnd_c >> LOG2_AVG);

    assign push_c               = ch_ok_c && last_c;
    assign pop_c                = !fifo_empty_c && bus.avg_ready;
    assign drop_c               = push_c && fifo_full_c && !pop_c;
    assign push_entry_c.channel = sel_c;
    assign push_entry_c.data    = avg_c;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (bus.avg_clear) begin
            acc_d    = '{default: '0};
            cnt_d    = '{default: '0};
            sticky_d = 1'b0;
        end else begin
            // The Nth sample restarts the channel even when its result is dropped.
            if (ch_ok_c) begin
                if (last_c) begin
                    acc_d[sel_c] = '0;
                    cnt_d[sel_c] = '0;
                end else begin
                    acc_d[sel_c] = sum_c;
                    cnt_d[sel_c] = cnt_q[sel_c] + CNT_W'(1);
                end
            end
            if (drop_c) sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    adc_avg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock_clk),
        .rst_n   (rst_n),
        .clear_i (bus.avg_clear),
        .push_i  (push_c),
        .din_i   (push_entry_c),
        .pop_i   (pop_c),
        .dout_o  (head_c),
        .empty_o (fifo_empty_c),
        .full_o  (fifo_full_c)
    );

    assign bus.avg_valid       = !fifo_empty_c;
    assign bus.avg_channel     = head_c.channel;
    assign bus.avg_data        = head_c.data;
    assign bus.overflow_sticky = sticky_q;

endmodule

// File: doc/adc_channel_averager.md
ADC_CHANNEL_AVERAGER -- requirements
Module: adc_channel_averager

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock is clock_clk and reset is reset_sink_reset_n.
REQ-002 Parameter LOG2_AVG, default 4, sets samples averaged per channel as N = 2^LOG2_AVG, with legal range 0..8.
REQ-003 Parameter NUM_CH, default 17, sets the number of channels tracked, with legal range 1..32.
REQ-004 Parameter FIFO_DEPTH, default 4, sets the output FIFO entries and SHALL be a power of 2 with a minimum of 2.
REQ-005 clock_clk  in  1  sole clock.
REQ-006 reset_sink_reset_n  in  1  asynchronous active-low reset.
REQ-007 response_valid  in  1  ADC sample strobe; there is no ready, so the block SHALL accept a sample every cycle.
REQ-008 response_channel  in  5  channel of the sample.
REQ-009 response_data  in  12  unsigned sample.
REQ-010 response_startofpacket, response_endofpacket  in  1 each  ignored.
REQ-011 avg_clear  in  1  synchronous clear of accumulators, counts, FIFO and sticky flag.
REQ-012 avg_valid  out  1  averaged result available.
REQ-013 avg_ready  in  1  consumer accepts the result when avg_valid and avg_ready are both high.
REQ-014 avg_channel  out  5  channel of the result.
REQ-015 avg_data  out  12  rounded average.
REQ-016 overflow_sticky  out  1  a completed average was dropped because the FIFO was full.

Function
REQ-017 Per channel c < NUM_CH, the block SHALL hold an accumulator acc[c] of 12+LOG2_AVG bits and a counter cnt[c] of LOG2_AVG bits.
REQ-018 A sample with response_channel >= NUM_CH SHALL be discarded with no state change.
REQ-019 On a valid sample that is not the Nth: acc[c] SHALL load acc[c]+data and cnt[c] SHALL load cnt[c]+1 at the same edge.
REQ-020 Back-to-back samples on the same channel SHALL be summed correctly with no stall or bubble.
REQ-021 On the Nth sample (cnt[c] = N-1): sum = acc[c]+data SHALL be pushed at that edge as {c, (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG}, and acc[c] and cnt[c] SHALL load 0.
REQ-022 With LOG2_AVG=0, every sample SHALL be forwarded unchanged with no rounding term.
REQ-023 The rounded result SHALL never exceed 4095, so no saturation logic is required.
REQ-024 Latency: avg_valid SHALL be high in the cycle after the edge that captured the Nth sample, provided the FIFO was empty.
REQ-025 The FIFO SHALL be first-word-fall-through; avg_channel and avg_data SHALL hold stable while avg_valid=1 and avg_ready=0.
REQ-026 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-027 A push with the FIFO full and no pop SHALL drop the result and set overflow_sticky; the channel SHALL still restart from 0.
REQ-028 Simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-029 avg_clear SHALL have priority over a same-cycle sample, which is discarded.
REQ-030 avg_clear SHALL zero all acc/cnt, empty the FIFO (avg_valid=0 next cycle) and clear overflow_sticky.

Reset
REQ-031 On reset assertion: all acc, cnt and FIFO pointers SHALL be 0, and avg_valid and overflow_sticky SHALL be 0.
REQ-032 On reset assertion: avg_channel and avg_data SHALL be 0.
REQ-033 Reset deassertion SHALL be synchronised to clock_clk internally, with a 2-flop release.
REQ-034 A reset asserted mid-accumulation SHALL discard all partial sums.

Structure
REQ-035 Package adc_avg_pkg SHALL hold ADC_DATA_W=12, ADC_CH_W=5, and the FIFO entry struct {channel, data}.
REQ-036 The FIFO SHALL be sub-module adc_avg_fifo, with parameterised depth, count-based full/empty, and first-word-fall-through output.

Verification
REQ-037 LOG2_AVG=2, channel 3 samples 10,11,12,13 consecutive, avg_ready=1 -> one result {3,12} (46+2>>2), avg_valid high the cycle after the 4th sample.
REQ-038 Interleaved ch0=4095 x4 and ch16=0 x4 -> results {0,4095} and {16,0}, in completion order.
REQ-039 avg_ready=0, FIFO_DEPTH=4, 5 completions -> 4 held in order, overflow_sticky=1, and the 5th is lost; avg_clear then empties the FIFO and clears the flag.
REQ-040 Sample on channel 20 with NUM_CH=17 -> no result, and channel 0..16 counts unaffected.
REQ-041 Reset pulse after 3 of 4 ch5 samples, then 4 samples of 8 -> {5,8}, with no contribution from before the reset.
REQ-042 FIFO full, then push and pop in the same cycle -> no drop, overflow_sticky stays 0, and order is preserved.
